// File: rtl/pidx_stream_pkg.sv
// Shared types and derived constants for the pidx_stream packed-index expander.
// Optional build macro PIDX_STREAM_OVERLAP_EN lets a new descriptor enter during the last beat.
package pidx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam int BSW_DFLT = 5;
  localparam int LW_DFLT  = 4;
  localparam int PW_DFLT  = 5;
  localparam int OW_DFLT  = 6;
  localparam int BS       = 1 << BSW_DFLT;
  localparam int TW       = LW_DFLT + BSW_DFLT;

  function automatic int bs_of(input int bsw);
    return 1 << bsw;
  endfunction

  function automatic int tw_of(input int lw, input int bsw);
    return lw + bsw;
  endfunction

  // "No element" marker: all ones at the given index width.
  function automatic longint idx_none(input int ow);
    return (longint'(1) << ow) - 1;
  endfunction

endpackage

// File: rtl/pidx_stream_if.sv
// Descriptor-in / beat-out handshake bundle for pidx_stream.
// Both channels: a transfer happens on a rising clk edge where valid && ready; a source holds its payload until then.
interface pidx_stream_if #(
  parameter int BSW = 5,
  parameter int LW  = 4,
  parameter int PW  = 5,
  parameter int OW  = 6
);
  localparam int BS = 1 << BSW;

  logic                   in_valid;
  logic                   in_ready;
  logic [BSW:0]           in_num;
  logic [BS-1:0][LW-1:0]  in_len;
  logic [BS-1:0][PW-1:0]  in_pos;
  logic                   out_valid;
  logic                   out_ready;
  logic [BS-1:0][OW-1:0]  out_index;
  logic [BS-1:0]          out_mask;
  logic                   out_last;

  modport master (
    output in_valid, in_num, in_len, in_pos, out_ready,
    input  in_ready, out_valid, out_index, out_mask, out_last
  );

  modport slave (
    input  in_valid, in_num, in_len, in_pos, out_ready,
    output in_ready, out_valid, out_index, out_mask, out_last
  );
endinterface

// File: rtl/pidx_stream_lane.sv
// One output lane: finds the element covering stream position p_i and forms its source index.
module pidx_lane
  import pidx_pkg::*;
#(
  parameter int BSW = 5,
  parameter int LW  = 4,
  parameter int PW  = 5,
  parameter int OW  = 6,
  localparam int BSL = 1 << BSW,
  localparam int TWL = LW + BSW
) (
  input  logic [TWL-1:0]            p_i,
  input  logic [BSL-1:0][TWL-1:0]   psum_i,
  input  logic [TWL-1:0]            total_i,
  input  logic [BSL-1:0][PW-1:0]    pos_i,
  output logic [OW-1:0]             index_o,
  output logic                      mask_o
);
  localparam int SW = ((PW > TWL) ? PW : TWL) + 1;
  localparam logic [OW-1:0] IDX_NONE = OW'(idx_none(OW));

  logic            found;
  logic [TWL-1:0]  prev;
  logic [TWL-1:0]  start;
  logic [PW-1:0]   sel_pos;
  logic [SW-1:0]   sum;

  // Prefix sums are monotonic, so the first element whose end lies past p owns p;
  // zero-length elements never satisfy psum > p ahead of their successor.
  always_comb begin
    found   = 1'b0;
    prev    = '0;
    start   = '0;
    sel_pos = '0;
    for (int j = 0; j < BSL; j++) begin
      if (!found && (psum_i[j] > p_i)) begin
        found   = 1'b1;
        sel_pos = pos_i[j];
        start   = prev;
      end
      prev = psum_i[j];
    end
    mask_o  = (p_i < total_i);
    sum     = SW'(sel_pos) + SW'(p_i - start);
    index_o = mask_o ? OW'(sum) : IDX_NONE;
  end
endmodule

// File: rtl/pps.sv
// Inclusive prefix sum over 2**NW operands: sum_o[j] = in_i[0] + ... + in_i[j].
module pps #(
  parameter int NW = 5,
  parameter int IW = 4,
  parameter int OW = 9
) (
  input  logic [2**NW-1:0][IW-1:0] in_i,
  output logic [2**NW-1:0][OW-1:0] sum_o
);
  logic [OW-1:0] acc;

  always_comb begin
    acc   = '0;
    sum_o = '0;
    for (int j = 0; j < 2**NW; j++) begin
      acc      = acc + OW'(in_i[j]);
      sum_o[j] = acc;
    end
  end
endmodule

// File: rtl/pidx_stream.sv
// Handshaked packed-index expander: descriptor -> prefix sums -> BS-lane index beats.
// Build macro PIDX_STREAM_OVERLAP_EN accepts the next descriptor on the last beat's handshake.
module pidx_stream
  import pidx_pkg::*;
#(
  parameter int BSW = 5,
  parameter int LW  = 4,
  parameter int PW  = 5,
  parameter int OW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  pidx_stream_if.slave     bus,
  output state_e           dbg_state_o
);
  localparam int BSL = bs_of(BSW);
  localparam int TWL = tw_of(LW, BSW);
  localparam logic [OW-1:0] IDX_NONE = OW'(idx_none(OW));

  state_e                  state_q, state_d;
  logic                    in_ready, out_valid, accept, hs, last_raw;
  logic [BSW:0]            num_q;
  logic [BSL-1:0][LW-1:0]  len_q, len_m;
  logic [BSL-1:0][PW-1:0]  pos_q;
  logic [BSL-1:0][TWL-1:0] psum_q, psum_d;
  logic [TWL-1:0]          total_q;
  logic [LW-1:0]           beat_q;
  logic [TWL:0]            end_pos;
  logic [TWL-1:0]          lane_p    [BSL];
  logic [OW-1:0]           lane_idx  [BSL];
  logic                    lane_mask [BSL];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SUM;
      SUM:     state_d = EMIT;
      EMIT:    if (hs && last_raw) state_d = accept ? SUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
`ifdef PIDX_STREAM_OVERLAP_EN
        in_ready  = last_raw && bus.out_ready;
`else
        in_ready  = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  assign accept      = bus.in_valid && in_ready;
  assign hs          = out_valid && bus.out_ready;
  assign dbg_state_o = state_q;

  // Beat b covers positions [b*BS, (b+1)*BS); it is last once that window reaches total.
  assign end_pos  = {({1'b0, beat_q} + (LW+1)'(1)), {BSW{1'b0}}};
  assign last_raw = (end_pos >= {1'b0, total_q});

  always_comb begin
    for (int j = 0; j < BSL; j++)
      len_m[j] = ((BSW+1)'(j) < num_q) ? len_q[j] : '0;
  end

  pps #(.NW(BSW), .IW(LW), .OW(TWL)) u_pps (
    .in_i  (len_m),
    .sum_o (psum_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q   <= '0;
      len_q   <= '0;
      pos_q   <= '0;
      psum_q  <= '0;
      total_q <= '0;
      beat_q  <= '0;
    end else begin
      if (accept) begin
        num_q <= (bus.in_num > (BSW+1)'(BSL)) ? (BSW+1)'(BSL) : bus.in_num;
        len_q <= bus.in_len;
        pos_q <= bus.in_pos;
      end
      if (state_q == SUM) begin
        psum_q  <= psum_d;
        total_q <= psum_d[BSL-1];
        beat_q  <= '0;
      end else if (hs && !last_raw) begin
        beat_q <= beat_q + LW'(1);
      end
    end
  end

  for (genvar k = 0; k < BSL; k++) begin : g_lane
    assign lane_p[k] = {beat_q, BSW'(k)};
    pidx_lane #(.BSW(BSW), .LW(LW), .PW(PW), .OW(OW)) u_lane (
      .p_i     (lane_p[k]),
      .psum_i  (psum_q),
      .total_i (total_q),
      .pos_i   (pos_q),
      .index_o (lane_idx[k]),
      .mask_o  (lane_mask[k])
    );
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_last  = out_valid && last_raw;
    for (int k = 0; k < BSL; k++) begin
      bus.out_index[k] = out_valid ? lane_idx[k] : IDX_NONE;
      bus.out_mask[k]  = out_valid && lane_mask[k];
    end
  end
endmodule

// File: doc/pidx_stream.md
Name: pidx_stream

Overview:
- Sequential, handshaked successor to the combinational packed-index generator.
- Takes one descriptor per transaction: up to BS variable-length elements, each with a length and a start position.
- Expands the descriptor into per-lane source indices, BS lanes per output beat.
- Lengths may total more than BS; the block then drains over as many beats as needed and holds off new input until done.
- Sits between the descriptor decoder and the lane-gather crossbar in the EAU datapath.

Parameters:
- BSW, 5, log2 of lane count; BS = 2**BSW.
- LW, 4, element length width; each length is 0..2**LW-1.
- PW, 5, element start-position width.
- OW, 6, output index width; the all-ones value means "no element".

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_num  in  BSW+1  element count; values above BS are clamped to BS
- in_len  in  LW x BS  per-element lengths
- in_pos  in  PW x BS  per-element start positions
- out_valid  out  1  beat valid
- out_ready  in  1  beat consumed when out_valid && out_ready
- out_index  out  OW x BS  per-lane source index
- out_mask  out  BS  lane holds a real element
- out_last  out  1  final beat of the transaction

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- FSM states:
  - IDLE: in_ready=1. On accept, latch num/len/pos and go to SUM.
  - SUM: one cycle. Register inclusive prefix sums psum[j] = len[0] + ... + len[j] for j < num (width TW = LW+BSW). Register total = psum[num-1], or 0 when num=0. Clear beat to 0. Go to EMIT.
  - EMIT: out_valid=1. On handshake: if out_last, go to IDLE; else beat++.
- Latency: descriptor accepted at edge t gives first out_valid at edge t+2.
- Lane k of beat b has stream position p = b*BS + k.
  - Element select: e = count of j < num with psum[j] <= p. Zero-length elements are skipped naturally.
  - Element start: start(e) = 0 if e=0, else psum[e-1].
  - Valid lane (p < total): out_mask[k]=1, out_index[k] = pos[e] + (p - start(e)), zero-extended and truncated to OW.
  - Empty lane: out_mask[k]=0, out_index[k] = all ones.
- out_last = ((b+1)*BS >= total).
  - total=0 gives exactly one beat: mask all 0, all indices all-ones, last=1.
- Beat counter is LW bits wide; the maximum is ceil(BS*(2**LW-1)/BS) - 1, so it never wraps.
- Output stability: out_index, out_mask and out_last derive only from registered state. They stay stable while out_valid && !out_ready.
- in_ready is 0 in SUM and EMIT (base build).
- Reset values: state IDLE, out_valid 0, in_ready 1 (after reset), beat 0, psum/total 0, out_mask 0, out_last 0. out_index reads all-ones while not valid.
- Reset mid-transaction drops the transaction. No partial beats follow.

Optional Feature:
- Macro PIDX_STREAM_OVERLAP_EN.
- Defined:
  - in_ready is also 1 in EMIT when out_last && out_ready.
  - A simultaneous accept moves EMIT directly to SUM, removing the IDLE bubble.
  - Sustained throughput becomes one descriptor per (beats+1) cycles.
- Undefined: in_ready only in IDLE, as above.

Decomposition:
- Package pidx_pkg:
  - state enum {IDLE, SUM, EMIT}
  - derived localparams BS and TW
  - the all-ones index constant as a function of OW
- Prefix sums reuse the existing pps parallel-prefix-sum block (NW=BSW, IW=LW, OW=TW).
- One sub-module, pidx_lane: combinational per-lane element select plus index/mask, instantiated BS times.

Test Plan:
All scenarios use BSW=2 (BS=4), LW=3, PW=4, OW=5, so the all-ones index is 31.
1. Two-beat spill: num=2, len={3,2}, pos={4,10}.
   - Beat0: index={4,5,6,10}, mask=1111, last=0.
   - Beat1: index={11,31,31,31}, mask=0001, last=1.
2. Empty descriptor: num=0 -> one beat, index all 31, mask=0000, last=1, then IDLE.
3. Zero-length skip: num=3, len={0,2,1}, pos={1,5,9} -> index={5,6,9,31}, mask=0111, last=1.
4. Backpressure: scenario 1 with out_ready=0 for 3 cycles on beat0.
   - Outputs stay {4,5,6,10}, beat stays 0, in_ready=0.
   - After release, beat1 follows on the next cycle.
5. Reset mid-EMIT: rst asserted during beat0 of scenario 1.
   - Next cycle: out_valid=0, in_ready=1.
   - A new descriptor then produces correct beats from beat 0.
6. Overlap, macro defined: back-to-back scenario-3 descriptors with out_ready=1.
   - out_valid is asserted every other cycle (SUM, EMIT, SUM, ...).
   - Macro undefined: one cycle in every three.
